// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer for a PLL-clocked system.
// Waits for a filtered PLL lock, releases N_DOM reset domains one at a time
// with a fixed stagger, and falls back to HOLD on lock loss or a software
// reset request. Lock-loss events are counted in a saturating counter.
module rst_seq_ctrl #(
   parameter int unsigned N_DOM       = 3,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LOCK_FILTER = 16,
   parameter int unsigned STAGGER     = 8,
   parameter int unsigned MIN_HOLD    = 32,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk_100M,
   input  logic             rst_n,
   input  logic             pll_lock,
   input  logic             sw_rst_req,
   output logic [N_DOM-1:0] rst_n_out,
   output logic             ready,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] lock_lost_cnt
);

   localparam int unsigned FILT_W = $clog2(LOCK_FILTER + 1);
   localparam int unsigned STAG_W = $clog2(STAGGER + 1);
   localparam int unsigned HOLD_W = $clog2(MIN_HOLD + 1);
   localparam int unsigned DOM_W  = $clog2(N_DOM + 1);

   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_RELEASE   = 3'd2,
      ST_RUN       = 3'd3,
      ST_HOLD      = 3'd4
   } state_e;

   // Synchronizer chains
   logic [SYNC_STAGES-1:0] rst_sync_q,  rst_sync_d;
   logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
   logic                   rst_int_n;
   logic                   lock_s;

   // Sequencer state
   state_e             state_q,    state_d;
   logic [FILT_W-1:0]  filt_cnt_q, filt_cnt_d;
   logic [STAG_W-1:0]  stag_cnt_q, stag_cnt_d;
   logic [DOM_W-1:0]   dom_idx_q,  dom_idx_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [N_DOM-1:0]   rst_out_q,  rst_out_d;
   logic               ready_q,    ready_d;
   logic [CNT_W-1:0]   lost_cnt_q, lost_cnt_d;

   // Shift a constant one into the reset chain and pll_lock into the lock chain
   always_comb begin
      rst_sync_d  = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
      lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
   end

   // Synchronizer flops: cleared asynchronously by the raw reset
   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q  <= '0;
         lock_sync_q <= '0;
      end else begin
         rst_sync_q  <= rst_sync_d;
         lock_sync_q <= lock_sync_d;
      end
   end

   // Internal reset asserts with rst_n, releases after the chain fills
   assign rst_int_n = rst_sync_q[SYNC_STAGES-1];
   assign lock_s    = lock_sync_q[SYNC_STAGES-1];

   // Next-state and next-output logic for the sequencer
   always_comb begin
      state_d    = state_q;
      filt_cnt_d = filt_cnt_q;
      stag_cnt_d = stag_cnt_q;
      dom_idx_d  = dom_idx_q;
      hold_cnt_d = hold_cnt_q;
      rst_out_d  = rst_out_q;
      ready_d    = 1'b0;
      lost_cnt_d = lost_cnt_q;

      case (state_q)
         ST_RESET: begin
            state_d    = ST_WAIT_LOCK;
            filt_cnt_d = '0;
            rst_out_d  = '0;
         end

         ST_WAIT_LOCK: begin
            // Software requests are ignored here; only the lock filter matters
            rst_out_d = '0;
            if (!lock_s) begin
               filt_cnt_d = '0;
            end else if (filt_cnt_q == FILT_W'(LOCK_FILTER - 1)) begin
               state_d    = ST_RELEASE;
               filt_cnt_d = '0;
               stag_cnt_d = '0;
               dom_idx_d  = DOM_W'(1);
               rst_out_d  = N_DOM'(1);
            end else begin
               filt_cnt_d = filt_cnt_q + FILT_W'(1);
            end
         end

         ST_RELEASE, ST_RUN: begin
            if (!lock_s) begin
               // Lock loss wins over a simultaneous software request
               state_d    = ST_HOLD;
               hold_cnt_d = '0;
               rst_out_d  = '0;
               if (lost_cnt_q != '1) begin
                  lost_cnt_d = lost_cnt_q + CNT_W'(1);
               end
            end else if (sw_rst_req) begin
               state_d    = ST_HOLD;
               hold_cnt_d = '0;
               rst_out_d  = '0;
            end else if (state_q == ST_RUN) begin
               ready_d = 1'b1;
            end else if (dom_idx_q == DOM_W'(N_DOM)) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
            end else if (stag_cnt_q == STAG_W'(STAGGER - 1)) begin
               // Domains are released strictly in index order
               rst_out_d  = rst_out_q | (N_DOM'(1) << dom_idx_q);
               dom_idx_d  = dom_idx_q + DOM_W'(1);
               stag_cnt_d = '0;
            end else begin
               stag_cnt_d = stag_cnt_q + STAG_W'(1);
            end
         end

         ST_HOLD: begin
            rst_out_d  = '0;
            filt_cnt_d = '0;
            if (sw_rst_req) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_W'(MIN_HOLD - 1)) begin
               state_d    = ST_WAIT_LOCK;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end

         default: begin
            // Illegal encodings recover through HOLD
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
            rst_out_d  = '0;
         end
      endcase
   end

   // Sequencer registers, cleared asynchronously by the internal reset
   always_ff @(posedge clk_100M or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q    <= ST_RESET;
         filt_cnt_q <= '0;
         stag_cnt_q <= '0;
         dom_idx_q  <= '0;
         hold_cnt_q <= '0;
         rst_out_q  <= '0;
         ready_q    <= 1'b0;
         lost_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         filt_cnt_q <= filt_cnt_d;
         stag_cnt_q <= stag_cnt_d;
         dom_idx_q  <= dom_idx_d;
         hold_cnt_q <= hold_cnt_d;
         rst_out_q  <= rst_out_d;
         ready_q    <= ready_d;
         lost_cnt_q <= lost_cnt_d;
      end
   end

   assign rst_n_out     = rst_out_q;
   assign ready         = ready_q;
   assign state         = state_q;
   assign lock_lost_cnt = lost_cnt_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed bench for rst_seq_ctrl with an expectation queue.
// Expected outputs are scheduled for absolute clock edges while stimulus is
// driven; a negedge monitor pops and compares them as the edges arrive.
module tb_rst_seq_ctrl;

   localparam logic [2:0] S_RST  = 3'd0;
   localparam logic [2:0] S_WL   = 3'd1;
   localparam logic [2:0] S_REL  = 3'd2;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;

   logic clk_100M = 1'b0;
   always #5 clk_100M = ~clk_100M;

   logic       rst_n, pll_lock, sw_rst_req, pll_lock_b, sw_rst_req_b;
   logic [2:0] rst_n_out;
   logic       ready;
   logic [2:0] state;
   logic [7:0] lock_lost_cnt;
   logic [0:0] rst_n_out_b;
   logic       ready_b;
   logic [2:0] state_b;
   logic [1:0] lock_lost_cnt_b;

   rst_seq_ctrl u_dut (
      .clk_100M      (clk_100M),
      .rst_n         (rst_n),
      .pll_lock      (pll_lock),
      .sw_rst_req    (sw_rst_req),
      .rst_n_out     (rst_n_out),
      .ready         (ready),
      .state         (state),
      .lock_lost_cnt (lock_lost_cnt)
   );

   rst_seq_ctrl #(
      .N_DOM       (1),
      .LOCK_FILTER (4),
      .STAGGER     (1),
      .MIN_HOLD    (4),
      .CNT_W       (2)
   ) u_dut_b (
      .clk_100M      (clk_100M),
      .rst_n         (rst_n),
      .pll_lock      (pll_lock_b),
      .sw_rst_req    (sw_rst_req_b),
      .rst_n_out     (rst_n_out_b),
      .ready         (ready_b),
      .state         (state_b),
      .lock_lost_cnt (lock_lost_cnt_b)
   );

   int cyc = 0;
   always @(posedge clk_100M) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   // Scoreboard: {dut_b, state[2:0], rst_n_out[2:0], ready, cnt[7:0]}
   int          exp_cyc_q[$];
   logic [15:0] exp_vec_q[$];
   string       exp_tag_q[$];

   function automatic logic [15:0] pack(input logic b, input logic [2:0] st,
                                        input logic [2:0] ro, input logic rd,
                                        input logic [7:0] c);
      return {b, st, ro, rd, c};
   endfunction

   function automatic logic [15:0] observe(input logic b);
      if (b) return {1'b1, state_b, 2'b00, rst_n_out_b, ready_b, 6'd0, lock_lost_cnt_b};
      return {1'b0, state, rst_n_out, ready, lock_lost_cnt};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed st=%0d rst_n_out=%b ready=%b cnt=%0d, expected st=%0d rst_n_out=%b ready=%b cnt=%0d",
                tag, obs[14:12], obs[11:9], obs[8], obs[7:0],
                exp[14:12], exp[11:9], exp[8], exp[7:0]);
      end
   endtask

   task automatic expect_at(input int c, input string tag, input logic [15:0] v);
      int i = 0;
      while (i < exp_cyc_q.size() && exp_cyc_q[i] <= c) i++;
      exp_cyc_q.insert(i, c);
      exp_vec_q.insert(i, v);
      exp_tag_q.insert(i, tag);
   endtask

   task automatic goto_edge(input int n);
      while (cyc < n) begin
         @(posedge clk_100M);
         #1;
      end
   endtask

   // Compare every expectation scheduled for the edge just taken
   always @(negedge clk_100M) begin
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
         if (exp_cyc_q[0] == cyc) begin
            chk(exp_tag_q[0], observe(exp_vec_q[0][15]), exp_vec_q[0]);
         end else begin
            n_vec++;
            n_err++;
            $error("FAIL %s: check for cycle %0d missed at cycle %0d", exp_tag_q[0], exp_cyc_q[0], cyc);
         end
         void'(exp_cyc_q.pop_front());
         void'(exp_vec_q.pop_front());
         void'(exp_tag_q.pop_front());
      end
   end

   int         e0, f0, x;
   logic [7:0] kc;

   initial begin
      rst_n        = 1'b0;
      pll_lock     = 1'b1;
      sw_rst_req   = 1'b0;
      pll_lock_b   = 1'b0;
      sw_rst_req_b = 1'b0;

      // Bring-up with constant lock: edge 0 is the edge before rst_n rises
      goto_edge(3);
      e0 = cyc;
      expect_at(e0,      "reset_state",     pack(0, S_RST,  3'b000, 0, 0));
      expect_at(e0,      "reset_state_b",   pack(1, S_RST,  3'b000, 0, 0));
      rst_n = 1'b1;
      expect_at(e0 + 2,  "rst_sync_delay",  pack(0, S_RST,  3'b000, 0, 0));
      expect_at(e0 + 3,  "wait_lock_entry", pack(0, S_WL,   3'b000, 0, 0));
      expect_at(e0 + 18, "filter_pending",  pack(0, S_WL,   3'b000, 0, 0));
      expect_at(e0 + 19, "release_dom0",    pack(0, S_REL,  3'b001, 0, 0));
      expect_at(e0 + 26, "stagger_hold0",   pack(0, S_REL,  3'b001, 0, 0));
      expect_at(e0 + 27, "release_dom1",    pack(0, S_REL,  3'b011, 0, 0));
      expect_at(e0 + 34, "stagger_hold1",   pack(0, S_REL,  3'b011, 0, 0));
      expect_at(e0 + 35, "release_dom2",    pack(0, S_REL,  3'b111, 0, 0));
      expect_at(e0 + 36, "run_ready",       pack(0, S_RUN,  3'b111, 1, 0));

      // Lock loss in RUN: two sync edges, then HOLD on the next edge
      goto_edge(e0 + 40);
      pll_lock = 1'b0;
      expect_at(e0 + 42, "lock_sync_delay", pack(0, S_RUN,  3'b111, 1, 0));
      expect_at(e0 + 43, "lock_loss_hold",  pack(0, S_HOLD, 3'b000, 0, 1));
      goto_edge(e0 + 50);
      pll_lock = 1'b1;
      goto_edge(e0 + 55);
      pll_lock = 1'b0;
      goto_edge(e0 + 57);
      pll_lock = 1'b1;
      expect_at(e0 + 60, "hold_lock_toggle", pack(0, S_HOLD, 3'b000, 0, 1));
      expect_at(e0 + 74, "hold_min_last",    pack(0, S_HOLD, 3'b000, 0, 1));
      expect_at(e0 + 75, "hold_exit",        pack(0, S_WL,   3'b000, 0, 1));

      // One-cycle lock glitch at filter count 10 restarts the filter
      goto_edge(e0 + 85);
      pll_lock = 1'b0;
      goto_edge(e0 + 86);
      pll_lock = 1'b1;
      expect_at(e0 + 91,  "filter_restart",   pack(0, S_WL,  3'b000, 0, 1));
      expect_at(e0 + 103, "filter_restart_b", pack(0, S_WL,  3'b000, 0, 1));
      expect_at(e0 + 104, "glitch_release",   pack(0, S_REL, 3'b001, 0, 1));
      expect_at(e0 + 112, "glitch_dom1",      pack(0, S_REL, 3'b011, 0, 1));
      expect_at(e0 + 120, "glitch_dom2",      pack(0, S_REL, 3'b111, 0, 1));
      expect_at(e0 + 121, "glitch_run",       pack(0, S_RUN, 3'b111, 1, 1));

      // Software reset pulse in RUN, then a second pulse that extends HOLD
      goto_edge(e0 + 125);
      expect_at(e0 + 125, "run_before_sw",    pack(0, S_RUN,  3'b111, 1, 1));
      sw_rst_req = 1'b1;
      goto_edge(e0 + 126);
      sw_rst_req = 1'b0;
      expect_at(e0 + 126, "sw_hold_no_count", pack(0, S_HOLD, 3'b000, 0, 1));
      goto_edge(e0 + 145);
      sw_rst_req = 1'b1;
      goto_edge(e0 + 146);
      sw_rst_req = 1'b0;
      expect_at(e0 + 158, "hold_extended",    pack(0, S_HOLD, 3'b000, 0, 1));
      expect_at(e0 + 177, "hold_ext_last",    pack(0, S_HOLD, 3'b000, 0, 1));
      expect_at(e0 + 178, "hold_exit_52",     pack(0, S_WL,   3'b000, 0, 1));

      // Software request is ignored while waiting for lock
      goto_edge(e0 + 184);
      sw_rst_req = 1'b1;
      goto_edge(e0 + 185);
      sw_rst_req = 1'b0;
      expect_at(e0 + 185, "wl_ignores_sw",  pack(0, S_WL,  3'b000, 0, 1));
      expect_at(e0 + 193, "wl_filter_last", pack(0, S_WL,  3'b000, 0, 1));
      expect_at(e0 + 194, "release_again",  pack(0, S_REL, 3'b001, 0, 1));

      // Lock loss and software request on the same edge count once
      goto_edge(e0 + 196);
      pll_lock = 1'b0;
      goto_edge(e0 + 198);
      sw_rst_req = 1'b1;
      expect_at(e0 + 198, "pre_simul",     pack(0, S_REL,  3'b001, 0, 1));
      expect_at(e0 + 199, "simul_loss_sw", pack(0, S_HOLD, 3'b000, 0, 2));
      goto_edge(e0 + 199);
      sw_rst_req = 1'b0;
      pll_lock   = 1'b1;
      expect_at(e0 + 231, "wl_after_simul", pack(0, S_WL,  3'b000, 0, 2));
      expect_at(e0 + 247, "rel_pre_async",  pack(0, S_REL, 3'b001, 0, 2));
      expect_at(e0 + 256, "rel_011",        pack(0, S_REL, 3'b011, 0, 2));

      // Asynchronous reset mid-RELEASE, checked between clock edges
      goto_edge(e0 + 257);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_reset", observe(1'b0), pack(0, S_RST, 3'b000, 0, 0));
      expect_at(e0 + 258, "reset_held",   pack(0, S_RST, 3'b000, 0, 0));
      expect_at(e0 + 258, "reset_held_b", pack(1, S_RST, 3'b000, 0, 0));

      // Second instance: one domain, 2-bit saturating lock-loss counter
      pll_lock_b = 1'b1;
      goto_edge(e0 + 262);
      f0 = cyc;
      rst_n = 1'b1;
      expect_at(f0 + 3, "b_wait_lock",  pack(1, S_WL,  3'b000, 0, 0));
      expect_at(f0 + 6, "b_filter",     pack(1, S_WL,  3'b000, 0, 0));
      expect_at(f0 + 7, "b_release",    pack(1, S_REL, 3'b001, 0, 0));
      expect_at(f0 + 8, "b_single_run", pack(1, S_RUN, 3'b001, 1, 0));
      for (int k = 0; k < 5; k++) begin
         x  = f0 + 10 + 14 * k;
         kc = (k < 3) ? 8'(k + 1) : 8'd3;
         goto_edge(x);
         pll_lock_b = 1'b0;
         expect_at(x + 3, "b_loss_hold", pack(1, S_HOLD, 3'b000, 0, kc));
         goto_edge(x + 3);
         pll_lock_b = 1'b1;
         expect_at(x + 12, "b_rerun", pack(1, S_RUN, 3'b001, 1, kc));
      end
      goto_edge(f0 + 10 + 14 * 5);

      // Drain any remaining expectations within a bounded wait
      for (int i = 0; i < 50 && exp_cyc_q.size() > 0; i++) @(posedge clk_100M);
      @(negedge clk_100M);
      #1;
      while (exp_cyc_q.size() > 0) begin
         n_vec++;
         n_err++;
         $error("FAIL %s: check for cycle %0d never reached (cycle %0d)", exp_tag_q[0], exp_cyc_q[0], cyc);
         void'(exp_cyc_q.pop_front());
         void'(exp_vec_q.pop_front());
         void'(exp_tag_q.pop_front());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter N_DOM, default 3, sets the number of reset domains (1..8).
REQ-002 Parameter SYNC_STAGES, default 2, sets the synchronizer depth (>=2).
REQ-003 Parameter LOCK_FILTER, default 16, sets the consecutive lock-high cycles required before release.
REQ-004 Parameter STAGGER, default 8, sets the cycles between successive domain releases (>=1).
REQ-005 Parameter MIN_HOLD, default 32, sets the minimum cycles spent in HOLD.
REQ-006 Parameter CNT_W, default 8, sets the lock-loss counter width.
REQ-007 Port clk_100M  input  1  system clock; all logic is rising-edge.
REQ-008 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 Port pll_lock  input  1  PLL lock, asynchronous to clk_100M.
REQ-010 Port sw_rst_req  input  1  synchronous software reset request, sampled every cycle.
REQ-011 Port rst_n_out  output  N_DOM  per-domain active-low resets, registered.
REQ-012 Port ready  output  1  high only in RUN.
REQ-013 Port state  output  3  RESET=0, WAIT_LOCK=1, RELEASE=2, RUN=3, HOLD=4.
REQ-014 Port lock_lost_cnt  output  CNT_W  saturating count of lock-loss events.

Function
REQ-015 rst_n is synchronized: internal reset asserts asynchronously and deasserts SYNC_STAGES edges after rst_n rises.
REQ-016 pll_lock passes through SYNC_STAGES flops (reset by rst_n) to form lock_s; only lock_s is used.
REQ-017 RESET: all outputs low; on the first edge with internal reset released, go to WAIT_LOCK.
REQ-018 WAIT_LOCK: the filter counter increments while lock_s=1 and clears when lock_s=0.
REQ-019 WAIT_LOCK: after LOCK_FILTER consecutive lock_s=1 cycles, go to RELEASE.
REQ-020 WAIT_LOCK: sw_rst_req is ignored.
REQ-021 RELEASE: rst_n_out[0] rises on the entry edge, and rst_n_out[k] rises exactly k*STAGGER edges after entry.
REQ-022 RELEASE: once a domain is released it stays high until HOLD or reset.
REQ-023 RELEASE: the edge after rst_n_out[N_DOM-1] rises, go to RUN and ready goes 1.
REQ-024 When N_DOM=1, RUN is entered one edge after RELEASE entry.
REQ-025 RELEASE or RUN with lock_s=0: on that edge go to HOLD, drive all rst_n_out and ready low, and increment lock_lost_cnt, saturating at all-ones.
REQ-026 RELEASE or RUN with sw_rst_req=1 and lock_s=1: go to HOLD with all outputs low; lock_lost_cnt is unchanged.
REQ-027 Simultaneous lock loss and sw_rst_req: treated as lock loss, so the counter increments once.
REQ-028 HOLD: rst_n_out all low; the hold counter starts at 0 on entry.
REQ-029 HOLD: after MIN_HOLD cycles go to WAIT_LOCK with the filter counter cleared, regardless of lock_s.
REQ-030 HOLD: sw_rst_req=1 clears the hold counter, extending HOLD.
REQ-031 HOLD: lock toggles do not increment lock_lost_cnt.
REQ-032 Domains are never released out of order, and no rst_n_out rises outside RELEASE.
REQ-033 Unused state encodings go to HOLD on the next edge.

Reset
REQ-034 While rst_n=0: state=RESET, rst_n_out=0, ready=0, lock_lost_cnt=0, and all counters and synchronizers are cleared.
REQ-035 rst_n falling at any time, including mid-RELEASE, forces rst_n_out low asynchronously with no clock required.

Verification
REQ-036 Defaults, pll_lock=1 constant, rst_n rises at edge 0 -> WAIT_LOCK entered at edge 3; RELEASE and rst_n_out=001 at edge 19; 011 at edge 27; 111 at edge 35; ready=1 at edge 36.
REQ-037 pll_lock drops for 1 cycle at filter count 10 in WAIT_LOCK -> filter restarts, and RELEASE occurs 16 lock-high cycles after recovery.
REQ-038 In RUN, pll_lock falls -> two cycles later (sync delay) rst_n_out=000, ready=0, lock_lost_cnt=1, state=HOLD; WAIT_LOCK follows 32 cycles later.
REQ-039 In RUN, sw_rst_req pulses 1 cycle -> HOLD, lock_lost_cnt unchanged; a second pulse at hold cycle 20 extends HOLD to 52 cycles total.
REQ-040 CNT_W=2, 5 lock-loss events -> lock_lost_cnt reads 1,2,3,3,3.
REQ-041 rst_n asserted mid-RELEASE with rst_n_out=011 -> rst_n_out=000 within the same cycle (asynchronous), state=RESET, lock_lost_cnt=0.
